seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream consumer of the address generator and the memory read port. Captures the 32-bit word read from instruction/data memory and shows it as 8 hex digits on the board's multiplexed, common-anode 7-segment display.
- Drives one digit at a time at a programmable scan rate. A blanking gap between digits prevents ghosting. A per-digit decimal-point mask shows status, e.g. the memory-select bit.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); minimum 4
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; must be < SCAN_DIV
CNT_W, 17, prescaler width; must satisfy 2^CNT_W >= SCAN_DIV

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  32  word from memory read port
load  input  1  single-cycle strobe: capture data_in into shadow register
dp_mask  input  8  bit i = 1 lights the decimal point of digit i; sampled live
blank  input  1  level: force all digits off while high
anode_n  output  8  digit enables, active-low; bit 0 = rightmost digit
seg_n  output  8  active-low segments {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (async assert, sync release): shadow=0, prescaler cnt=0, digit_idx=0, anode_n=8'hFF, seg_n=8'hFF. Reset mid-scan clears immediately, with no partial update.
- Shadow: on a clk edge with load=1, shadow<=data_in. Without load, shadow holds. The display never shows data_in directly.
- Prescaler: cnt counts 0..SCAN_DIV-1.
  - At cnt==SCAN_DIV-1: cnt<=0 and digit_idx<=digit_idx+1 (3-bit, wraps 7->0).
  - The prescaler runs regardless of blank and load.
- Outputs are registered and computed from the previous-cycle state:
  - anode_n(t+1) = 8'hFF if blank(t)=1 or cnt(t)<BLANK_CYC; otherwise ~(1<<digit_idx(t)).
  - seg_n[6:0](t+1) = hex_decode(shadow(t)[4*digit_idx(t)+3 -: 4]).
  - seg_n[7](t+1) = ~dp_mask[digit_idx(t)].
  - seg_n keeps updating during blanking; only anode_n is forced off.
- Latency:
  - load at edge t -> shadow valid after t -> seg_n reflects it after edge t+1 (2 cycles from the load strobe).
  - blank asserted -> anode_n=8'hFF after the next edge. Deassert -> normal scan resumes on the next edge, at the current cnt/digit.
- hex_decode ({g..a}, active-low):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- Simultaneous load and digit advance: both take effect; the new digit shows old shadow for 1 cycle, which is invisible because it falls inside blanking.
- A load held high for multiple cycles captures every cycle; the last value wins.
- Exactly one anode is low at any time outside blanking; never more than one.

Test Plan (SCAN_DIV=8, BLANK_CYC=2 for all):
- Reset: hold rst_n=0 with load=1 and data_in=32'hFFFFFFFF -> anode_n=8'hFF, seg_n=8'hFF throughout. Release -> first lit digit is digit 0 with seg_n=8'hC0 (shadow=0, "0").
- Scan order/timing: load 32'h01234567 -> over 64 cycles anode_n walks FE,FD,...,7F.
  - Each digit lit 6 cycles, all-off 2 cycles.
  - seg_n per digit 0..7 = F8,82,92,99,B0,A4,F9,C0.
  - Wrap 7->0 with no double-lit anode.
- Load latency: mid-slot on digit 2, load 32'hFFFFFFFF -> seg_n changes from prior value to 8'h8E exactly 2 edges after the load edge. No change without load even if data_in toggles.
- Blank: assert blank for 10 cycles during digit 5 -> anode_n=8'hFF from the next edge. Prescaler continues, so after release the digit is 6 or 7 as counted, not 5.
- DP mask: dp_mask=8'h80, data 32'h89ABCDEF -> seg_n[7]=0 only while anode_n=7F; digit 7 seg_n=8'h00.
- Async reset mid-scan: pull rst_n low between edges while digit 4 is lit -> anode_n=8'hFF immediately, without waiting for a clk edge. After release, the scan restarts at digit 0 with cnt=0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Shows a captured 32-bit word as 8 hex digits on a multiplexed common-anode 7-segment display.
// Outputs are registered from the previous-cycle scan state; each digit slot opens with an all-off gap.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter int unsigned CNT_W     = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  dp_mask,
  input  logic        blank,
  output logic [7:0]  anode_n,
  output logic [7:0]  seg_n
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 4");
  end
  if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank_cyc
    $error("BLANK_CYC must be smaller than SCAN_DIV");
  end
  if ((64'd1 << CNT_W) < 64'(SCAN_DIV)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for SCAN_DIV");
  end

  logic [31:0]      shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [7:0]       anode_q, anode_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       nibble;
  logic [6:0]       glyph;

  // Glyph bits are {g,f,e,d,c,b,a}, active-low.
  always_comb begin
    nibble = shadow_q[{digit_q, 2'b00} +: 4];
    glyph  = 7'b1111111;
    case (nibble)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'b1111111;
    endcase
  end

  always_comb begin
    shadow_d = load ? data_in : shadow_q;
    cnt_d    = cnt_q + CNT_W'(1);
    digit_d  = digit_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + 3'd1;
    end
    // Segments keep tracking the scan during the gap; only the anodes are held off.
    anode_d = (blank || (cnt_q < CNT_BLANK)) ? 8'hFF : ~(8'h01 << digit_q);
    seg_d   = {~dp_mask[digit_q], glyph};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      digit_q  <= '0;
      anode_q  <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
    end
  end

  assign anode_n = anode_q;
  assign seg_n   = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  dp_mask;
  logic        blank;
  logic [7:0]  anode_n;
  logic [7:0]  seg_n;

  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2), .CNT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .load    (load),
    .dp_mask (dp_mask),
    .blank   (blank),
    .anode_n (anode_n),
    .seg_n   (seg_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [7:0] seg;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   ncyc   = 0;
  int   checks = 0;
  int   errors = 0;

  // Expected scan position (edges since reset release) and shadow contents.
  int          p  = 0;
  logic [31:0] sh = '0;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [7:0] scan_seg [8] = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  logic [7:0] dp_seg   [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h00};

  always @(negedge clk) begin
    ncyc++;
    checks++;
    if ($countones(~anode_n) > 1) begin
      errors++;
      $display("FAIL one_hot cyc=%0d anode_n=%h (at most one low bit required)", ncyc, anode_n);
    end
    while (sbq.size() > 0 && sbq[0].cyc <= ncyc) begin
      mon_e = sbq.pop_front();
      checks++;
      if (mon_e.cyc != ncyc || anode_n !== mon_e.an || seg_n !== mon_e.seg) begin
        errors++;
        $display("FAIL %s cyc=%0d anode_n=%h seg_n=%h required anode_n=%h seg_n=%h (due cyc %0d)",
                 mon_e.nm, ncyc, anode_n, seg_n, mon_e.an, mon_e.seg, mon_e.cyc);
      end
    end
  end

  task automatic push(input int cyc, input logic [7:0] an, input logic [7:0] sg, input string nm);
    exp_t e;
    e.cyc = cyc; e.an = an; e.seg = sg; e.nm = nm;
    sbq.push_back(e);
  endtask

  // Called just after an active edge: expectation for the output that edge produced.
  task automatic expect_now(input logic [7:0] an, input logic [7:0] sg, input string nm);
    push(ncyc + 1, an, sg, nm);
  endtask

  task automatic step();
    logic [7:0] ea, es;
    int c, d;
    c = p % 8;
    d = (p / 8) % 8;
    if (!rst_n) begin
      ea = 8'hFF;
      es = 8'hFF;
    end else begin
      ea = (blank || c < 2) ? 8'hFF : 8'(~(8'h01 << d));
      es = {~dp_mask[d], hex_tab[sh[4*d +: 4]]};
    end
    @(posedge clk);
    if (rst_n) begin
      if (load) sh = data_in;
      p++;
    end
    #1;
    push(ncyc + 1, ea, es, "model");
  endtask

  task automatic run_until(input int target);
    while (p < target) begin
      data_in = $urandom();
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d;
    rst_n = 1'b0; load = 1'b1; data_in = 32'hFFFF_FFFF; dp_mask = 8'h00; blank = 1'b0;

    // Reset held with a live load: nothing may be captured or lit.
    repeat (4) step();
    rst_n = 1'b1; load = 1'b0;
    repeat (3) step();
    expect_now(8'hFE, 8'hC0, "rst_first_digit");

    load = 1'b1; data_in = 32'h0123_4567;
    step();
    load = 1'b0;
    run_until(64);

    // Full scan of 01234567 plus the 7->0 wrap; data_in toggles without load.
    while (p < 130) begin
      c = p % 8; d = (p / 8) % 8;
      data_in = $urandom();
      step();
      if (c >= 2) expect_now(8'(~(8'h01 << d)), scan_seg[d], "scan_lit");
      else        expect_now(8'hFF, scan_seg[d], "scan_gap");
    end

    // Load mid-slot on digit 2: seg changes exactly two edges after the strobe edge.
    run_until(148);
    load = 1'b1; data_in = 32'hFFFF_FFFF;
    step();
    expect_now(8'hFB, 8'h92, "load_edge_old");
    load = 1'b0; data_in = 32'h1234_5678;
    step();
    expect_now(8'hFB, 8'h8E, "load_plus1_new");

    // Blank for 10 cycles during digit 5; prescaler keeps counting.
    run_until(171);
    blank = 1'b1;
    step();
    expect_now(8'hFF, 8'h8E, "blank_on");
    repeat (9) step();
    blank = 1'b0;
    step();
    expect_now(8'hBF, 8'h8E, "blank_resume_digit6");

    // Decimal point on digit 7 only.
    dp_mask = 8'h80; load = 1'b1; data_in = 32'h89AB_CDEF;
    step();
    load = 1'b0;
    run_until(192);
    while (p < 256) begin
      c = p % 8; d = (p / 8) % 8;
      step();
      if (c >= 2) expect_now(8'(~(8'h01 << d)), dp_seg[d], "dp_lit");
    end

    // Async reset while digit 4 is lit; the expectation for this cycle is replaced.
    run_until(292);
    while (sbq.size() > 0 && sbq[$].cyc == ncyc + 1) void'(sbq.pop_back());
    rst_n = 1'b0;
    expect_now(8'hFF, 8'hFF, "arst_immediate");
    p = 0; sh = '0; dp_mask = 8'h00;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    expect_now(8'hFE, 8'hC0, "arst_restart_digit0");
    run_until(20);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
